// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and the SRAM slave FSM state type.
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_STALL,
    ERR1,
    ERR2
  } sram_state_t;

endpackage

// File: rtl/ahb2_sram_slave_if.sv
// AHB2 bus bundle between a master and the SRAM slave endpoint.
interface ahb2_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb2_sram_addr_decode.sv
// Address/size decode: SRAM word address, byte lanes and the error flag.
module ahb2_sram_addr_decode
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [31:0]           haddr,
  input  logic [2:0]            hsize,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic [3:0]            be,
  output logic                  err
);

  logic out_of_range;
  logic misaligned;

  // 33-bit compare keeps the limit representable for the widest SRAM.
  assign out_of_range = ({1'b0, haddr} >= (33'd4 << ADDR_WIDTH));
  assign word_addr    = haddr[ADDR_WIDTH+1:2];

  always_comb begin
    be         = '0;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << haddr[1:0];
      HSIZE_HALF: begin
        be         = 4'b0011 << {haddr[1], 1'b0};
        misaligned = haddr[0];
      end
      HSIZE_WORD: begin
        be         = 4'b1111;
        misaligned = (haddr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign err = misaligned | out_of_range;

endmodule

// File: rtl/ahb2_sram_slave.sv
// AHB2 slave that maps transfers onto a single-port synchronous 32-bit SRAM,
// inserting one wait state when a read address phase collides with a write.
module ahb2_sram_slave
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter bit          RESP_ERR_EN = 1'b1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahb2_sram_slave_if.slave      ahb,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [3:0]            sram_be,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  sram_state_t           state;
  logic                  hready_q;
  logic [1:0]            hresp_q;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_be;

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [3:0]            dec_be;
  logic                  dec_err;
  logic                  accept;

  ahb2_sram_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_decode (
    .haddr     (ahb.haddr),
    .hsize     (ahb.hsize),
    .word_addr (dec_addr),
    .be        (dec_be),
    .err       (dec_err)
  );

  assign accept = ahb.hsel & hready_q & ahb.htrans[1];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      lat_addr <= '0;
      lat_be   <= '0;
    end else begin
      case (state)
        RD_STALL: begin
          state    <= RD;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
        ERR1: begin
          state    <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state    <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          if (accept) begin
            if (dec_err) begin
              if (RESP_ERR_EN) begin
                state    <= ERR1;
                hready_q <= 1'b0;
                hresp_q  <= HRESP_ERROR;
              end
            end else if (ahb.hwrite) begin
              state    <= WR;
              lat_addr <= dec_addr;
              lat_be   <= dec_be;
            end else if (state == WR) begin
              // SRAM port is busy with the write data phase: replay the read next cycle.
              state    <= RD_STALL;
              hready_q <= 1'b0;
              lat_addr <= dec_addr;
              lat_be   <= dec_be;
            end else begin
              state <= RD;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = '0;
    sram_wdata = '0;
    if (!hreset) begin
      if (state == WR) begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = lat_addr;
        sram_be    = lat_be;
        sram_wdata = ahb.hwdata;
      end else if (state == RD_STALL) begin
        sram_cs   = 1'b1;
        sram_addr = lat_addr;
        sram_be   = lat_be;
      end else if (accept && !ahb.hwrite && !dec_err) begin
        sram_cs   = 1'b1;
        sram_addr = dec_addr;
        sram_be   = dec_be;
      end
    end
  end

  assign ahb.hready = hready_q;
  assign ahb.hresp  = hresp_q;
  assign ahb.hrdata = (state == RD) ? sram_rdata : '0;

endmodule

// File: tb/tb_ahb2_sram_slave.sv
// Directed bench for ahb2_sram_slave: error-responding instance with an SRAM
// model, plus a RESP_ERR_EN=0 instance fed the same bus for the ignore case.
module tb_ahb2_sram_slave;
  import ahb2_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  logic preload;
  always #5 hclk = ~hclk;

  ahb2_sram_slave_if bus0 ();
  ahb2_sram_slave_if bus1 ();

  assign bus1.hsel   = bus0.hsel;
  assign bus1.haddr  = bus0.haddr;
  assign bus1.htrans = bus0.htrans;
  assign bus1.hwrite = bus0.hwrite;
  assign bus1.hsize  = bus0.hsize;
  assign bus1.hburst = bus0.hburst;
  assign bus1.hprot  = bus0.hprot;
  assign bus1.hwdata = bus0.hwdata;

  logic        cs0, we0, cs1, we1;
  logic [9:0]  addr0, addr1;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, rdata0;
  logic [31:0] rdata1;
  assign rdata1 = '0;

  ahb2_sram_slave #(.ADDR_WIDTH(10), .RESP_ERR_EN(1'b1)) dut0 (
    .hclk(hclk), .hreset(hreset), .ahb(bus0),
    .sram_cs(cs0), .sram_we(we0), .sram_addr(addr0), .sram_be(be0),
    .sram_wdata(wdata0), .sram_rdata(rdata0)
  );

  ahb2_sram_slave #(.ADDR_WIDTH(10), .RESP_ERR_EN(1'b0)) dut1 (
    .hclk(hclk), .hreset(hreset), .ahb(bus1),
    .sram_cs(cs1), .sram_we(we1), .sram_addr(addr1), .sram_be(be1),
    .sram_wdata(wdata1), .sram_rdata(rdata1)
  );

  logic [31:0] mem [1024];

  always @(posedge hclk) begin
    if (preload) begin
      mem[0] <= 32'h1111_1111;
      mem[1] <= 32'h2222_2222;
      mem[2] <= 32'h3333_3333;
      mem[4] <= 32'h0000_0000;
      mem[8] <= 32'h0000_0000;
    end else if (cs0) begin
      if (we0) begin
        for (int i = 0; i < 4; i++)
          if (be0[i]) mem[addr0][8*i +: 8] <= wdata0[8*i +: 8];
      end else begin
        rdata0 <= mem[addr0];
      end
    end
  end

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic write, input logic [2:0] size);
    bus0.hsel   = sel;
    bus0.haddr  = addr;
    bus0.htrans = trans;
    bus0.hwrite = write;
    bus0.hsize  = size;
    bus0.hburst = HBURST_INCR;
    bus0.hprot  = 4'b0011;
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1;
    preload = 1'b1;
    idle();
    bus0.hwdata = '0;

    // Reset values
    @(negedge hclk);
    chk("rst_hready", bus0.hready, 1);
    chk("rst_hresp", bus0.hresp, HRESP_OKAY);
    chk("rst_hrdata", bus0.hrdata, 0);
    chk("rst_cs", cs0, 0);
    cyc();
    hreset = 1'b0;
    preload = 1'b0;

    // Word write 0x10 then read 0x10: one stall cycle
    cyc(); drive(1'b1, 32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    @(negedge hclk);
    chk("wr_ap_cs", cs0, 0);
    chk("wr_ap_hready", bus0.hready, 1);
    cyc(); bus0.hwdata = 32'hDEAD_BEEF; drive(1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("wr_cs", cs0, 1);
    chk("wr_we", we0, 1);
    chk("wr_addr", addr0, 4);
    chk("wr_be", be0, 4'hF);
    chk("wr_wdata", wdata0, 32'hDEAD_BEEF);
    chk("wr_hready", bus0.hready, 1);
    cyc();
    @(negedge hclk);
    chk("stall_hready", bus0.hready, 0);
    chk("stall_hresp", bus0.hresp, HRESP_OKAY);
    chk("stall_cs", cs0, 1);
    chk("stall_we", we0, 0);
    chk("stall_addr", addr0, 4);
    cyc(); idle();
    @(negedge hclk);
    chk("raw_hready", bus0.hready, 1);
    chk("raw_hrdata", bus0.hrdata, 32'hDEAD_BEEF);
    chk("raw_hresp", bus0.hresp, HRESP_OKAY);

    // Byte write 0xAA to 0x11, then word read of 0x10
    cyc(); drive(1'b1, 32'h11, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE);
    cyc(); bus0.hwdata = 32'h0000_AA00; drive(1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("bw_be", be0, 4'b0010);
    chk("bw_we", we0, 1);
    cyc();
    @(negedge hclk);
    chk("bw_stall_hready", bus0.hready, 0);
    cyc(); idle();
    @(negedge hclk);
    chk("bw_rd_hrdata", bus0.hrdata, 32'hDEAD_AAEF);
    chk("bw_rd_hready", bus0.hready, 1);

    // Back-to-back reads, zero wait states
    cyc(); drive(1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("b2b_hready0", bus0.hready, 1);
    chk("b2b_cs0", cs0, 1);
    chk("b2b_addr0", addr0, 0);
    cyc(); drive(1'b1, 32'h4, HTRANS_SEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("b2b_hready1", bus0.hready, 1);
    chk("b2b_data0", bus0.hrdata, 32'h1111_1111);
    chk("b2b_addr1", addr0, 1);
    cyc(); drive(1'b1, 32'h8, HTRANS_SEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("b2b_hready2", bus0.hready, 1);
    chk("b2b_data1", bus0.hrdata, 32'h2222_2222);
    cyc(); idle();
    @(negedge hclk);
    chk("b2b_hready3", bus0.hready, 1);
    chk("b2b_data2", bus0.hrdata, 32'h3333_3333);

    // Misaligned halfword, then hsize=3 sampled during ERR2
    cyc(); drive(1'b1, 32'h3, HTRANS_NONSEQ, 1'b0, HSIZE_HALF);
    @(negedge hclk);
    chk("mis_ap_cs", cs0, 0);
    cyc(); idle();
    @(negedge hclk);
    chk("mis_err1_hready", bus0.hready, 0);
    chk("mis_err1_hresp", bus0.hresp, HRESP_ERROR);
    chk("mis_err1_cs", cs0, 0);
    cyc(); drive(1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, 3'b011);
    @(negedge hclk);
    chk("mis_err2_hready", bus0.hready, 1);
    chk("mis_err2_hresp", bus0.hresp, HRESP_ERROR);
    chk("sz3_ap_cs", cs0, 0);
    cyc(); idle();
    @(negedge hclk);
    chk("sz3_err1_hready", bus0.hready, 0);
    chk("sz3_err1_hresp", bus0.hresp, HRESP_ERROR);
    chk("sz3_err1_cs", cs0, 0);
    cyc();
    @(negedge hclk);
    chk("sz3_err2_hready", bus0.hready, 1);
    chk("sz3_err2_hresp", bus0.hresp, HRESP_ERROR);
    cyc();
    @(negedge hclk);
    chk("post_err_hresp", bus0.hresp, HRESP_OKAY);

    // Out-of-range 0x1000: ERROR on dut0, ignored OKAY on dut1
    cyc(); drive(1'b1, 32'h1000, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("oor_cs0", cs0, 0);
    chk("oor_cs1", cs1, 0);
    chk("oor_hready1_ap", bus1.hready, 1);
    cyc(); idle();
    @(negedge hclk);
    chk("oor_err1_hready", bus0.hready, 0);
    chk("oor_err1_hresp", bus0.hresp, HRESP_ERROR);
    chk("oor_noerr_hready", bus1.hready, 1);
    chk("oor_noerr_hresp", bus1.hresp, HRESP_OKAY);
    chk("oor_noerr_cs", cs1, 0);
    cyc();
    @(negedge hclk);
    chk("oor_err2_hready", bus0.hready, 1);
    chk("oor_err2_hresp", bus0.hresp, HRESP_ERROR);

    // Reset asserted during RD_STALL
    cyc(); drive(1'b1, 32'h20, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    cyc(); bus0.hwdata = 32'h1234_5678; drive(1'b1, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("rs_wr_cs", cs0, 1);
    chk("rs_wr_addr", addr0, 8);
    cyc();
    @(negedge hclk);
    chk("rs_stall_hready", bus0.hready, 0);
    #2 hreset = 1'b1;
    #1;
    chk("rs_async_hready", bus0.hready, 1);
    chk("rs_async_hresp", bus0.hresp, HRESP_OKAY);
    chk("rs_async_cs", cs0, 0);
    cyc(); idle(); hreset = 1'b0;
    @(negedge hclk);
    chk("rs_next_hready", bus0.hready, 1);
    chk("rs_next_hresp", bus0.hresp, HRESP_OKAY);
    chk("rs_next_cs", cs0, 0);
    chk("rs_next_hrdata", bus0.hrdata, 0);
    cyc(); drive(1'b1, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    @(negedge hclk);
    chk("rs_rd_cs", cs0, 1);
    chk("rs_rd_addr", addr0, 8);
    cyc(); idle();
    @(negedge hclk);
    chk("rs_rd_hrdata", bus0.hrdata, 32'h1234_5678);
    chk("rs_rd_hready", bus0.hready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
